// File: rtl/checking_tester_if.sv
// Stimulus and result handshake bundle between the harness and the DUT.
// The harness takes the master side; the DUT (or its wrapper) the slave side.
interface checking_tester_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) ();
  logic             stim_valid;
  logic             stim_yumi;
  logic [IN_W-1:0]  stim_data;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;

  modport master (
    output stim_valid, stim_data, res_ready,
    input  stim_yumi, res_valid, res_data
  );

  modport slave (
    input  stim_valid, stim_data, res_ready,
    output stim_yumi, res_valid, res_data
  );
endinterface

// File: rtl/checking_tester.sv
// Streams ROM test vectors into a DUT and checks its in-order results
// against an expected-value ROM, with bounded outstanding vectors.
module checking_tester #(
  parameter int IN_WORD_SIZE    = 16,
  parameter int IN_NUM_WORDS    = 1,
  parameter int OUT_WORD_SIZE   = 16,
  parameter int OUT_NUM_WORDS   = 1,
  parameter int NUM_TESTS       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TOLERANCE       = 0,
  parameter logic [NUM_TESTS*IN_NUM_WORDS*IN_WORD_SIZE-1:0]
    IN_INIT = '0,
  parameter logic [NUM_TESTS*OUT_NUM_WORDS*OUT_WORD_SIZE-1:0]
    EXP_INIT = '0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  input  logic loop_i,
  checking_tester_if.master bus,
  output logic busy_o,
  output logic done_o,
  output logic pass_o,
  output logic [$clog2(NUM_TESTS+1)-1:0] error_count_o,
  output logic first_fail_valid_o,
  output logic [$clog2(NUM_TESTS)-1:0] first_fail_idx_o,
  output logic [15:0] pass_count_o
);

  localparam int IW  = IN_NUM_WORDS * IN_WORD_SIZE;
  localparam int OW  = OUT_NUM_WORDS * OUT_WORD_SIZE;
  localparam int PW  = $clog2(NUM_TESTS);
  localparam int CW  = $clog2(NUM_TESTS + 1);
  localparam int OSW = $clog2(MAX_OUTSTANDING + 1);
  localparam int OWP = OUT_WORD_SIZE + 1;

  localparam logic [CW-1:0]  NT   = CW'(NUM_TESTS);
  localparam logic [PW-1:0]  LAST = PW'(NUM_TESTS - 1);
  localparam logic [OSW-1:0] MAXO = OSW'(MAX_OUTSTANDING);
  localparam logic signed [OWP-1:0] TOL = OWP'(TOLERANCE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [PW-1:0]  send_ptr_q;
  logic [PW-1:0]  send_ptr_d;
  logic [PW-1:0]  recv_ptr_q;
  logic [CW-1:0]  sent_q;
  logic [OSW-1:0] outst_q;
  logic [CW-1:0]  err_q;
  logic           ffv_q;
  logic [PW-1:0]  ffi_q;
  logic [15:0]    pass_q;
  logic [IW-1:0]  data_q;

  logic          run;
  logic          valid;
  logic          ready;
  logic          send_fire;
  logic          recv_fire;
  logic          last_recv;
  logic          mismatch;
  logic [IW-1:0] in_rd;
  logic [OW-1:0] exp_vec;

  function automatic logic word_bad(
    input logic [OUT_WORD_SIZE-1:0] a,
    input logic [OUT_WORD_SIZE-1:0] b
  );
    logic signed [OWP-1:0] d;
    d = $signed({a[OUT_WORD_SIZE-1], a})
      - $signed({b[OUT_WORD_SIZE-1], b});
    if (d[OWP-1]) d = -d;
    return d > TOL;
  endfunction

  assign run   = state_q == RUN;
  assign valid = run && (sent_q < NT) && (outst_q < MAXO);
  assign ready = run && (outst_q != '0);

  assign send_fire = valid && bus.stim_yumi;
  assign recv_fire = ready && bus.res_valid;
  assign last_recv = recv_fire && (recv_ptr_q == LAST);

  assign in_rd   = IN_INIT[int'(send_ptr_d)*IW +: IW];
  assign exp_vec = EXP_INIT[int'(recv_ptr_q)*OW +: OW];

  always_comb begin
    mismatch = 1'b0;
    for (int w = 0; w < OUT_NUM_WORDS; w++) begin
      if (word_bad(bus.res_data[w*OUT_WORD_SIZE +: OUT_WORD_SIZE],
                   exp_vec[w*OUT_WORD_SIZE +: OUT_WORD_SIZE]))
        mismatch = 1'b1;
    end
  end

  // ROM is read at the next pointer so data_o is ready with no bubble
  always_comb begin
    send_ptr_d = send_ptr_q;
    if (!run) begin
      if (start_i) send_ptr_d = '0;
    end else if (last_recv && loop_i) begin
      send_ptr_d = '0;
    end else if (send_fire) begin
      send_ptr_d = (send_ptr_q == LAST) ? '0 : send_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      send_ptr_q <= '0;
      recv_ptr_q <= '0;
      sent_q     <= '0;
      outst_q    <= '0;
      err_q      <= '0;
      ffv_q      <= 1'b0;
      ffi_q      <= '0;
      pass_q     <= '0;
      data_q     <= IN_INIT[IW-1:0];
    end else begin
      send_ptr_q <= send_ptr_d;
      data_q     <= in_rd;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q    <= RUN;
            recv_ptr_q <= '0;
            sent_q     <= '0;
            outst_q    <= '0;
            err_q      <= '0;
            ffv_q      <= 1'b0;
            ffi_q      <= '0;
            pass_q     <= '0;
          end
        end
        RUN: begin
          if (send_fire) sent_q <= sent_q + 1'b1;
          if (send_fire && !recv_fire)
            outst_q <= outst_q + 1'b1;
          else if (!send_fire && recv_fire)
            outst_q <= outst_q - 1'b1;
          if (recv_fire) begin
            recv_ptr_q <= (recv_ptr_q == LAST) ? '0
                        : recv_ptr_q + 1'b1;
            if (mismatch) begin
              if (err_q != '1) err_q <= err_q + 1'b1;
              if (!ffv_q) begin
                ffv_q <= 1'b1;
                ffi_q <= recv_ptr_q;
              end
            end
          end
          if (last_recv) begin
            if (loop_i) begin
              sent_q <= '0;
              pass_q <= pass_q + 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stim_valid = valid;
  assign bus.stim_data  = data_q;
  assign bus.res_ready  = ready;

  assign busy_o             = run;
  assign done_o             = state_q == DONE;
  assign pass_o             = done_o && (err_q == '0);
  assign error_count_o      = err_q;
  assign first_fail_valid_o = ffv_q;
  assign first_fail_idx_o   = ffi_q;
  assign pass_count_o       = pass_q;

endmodule
